// File: rtl/data_mem_copy_engine_if.sv
// ============================================================================
// Module      : data_mem_copy_engine_if
// Description : Bus bundle between the CPU/memory environment and the
//               data-memory copy engine. The slave modport is the engine;
//               the master modport is the surrounding CPU and memory.
//               The fill signals exist only with DATA_MEM_COPY_FILL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface data_mem_copy_engine_if #(
  parameter int W = 8,
  parameter int A = 8
);
  // Copy request
  logic         Start;
  logic [A-1:0] SrcAddr;
  logic [A-1:0] DstAddr;
  logic [A-1:0] Length;
`ifdef DATA_MEM_COPY_FILL_EN
  logic         Fill;
  logic [W-1:0] FillValue;
`endif
  // CPU load/store path
  logic         CpuWriteEn;
  logic [A-1:0] CpuAddress;
  logic [W-1:0] CpuDataIn;
  logic [W-1:0] CpuDataOut;
  // Data memory port
  logic         MemWriteEn;
  logic [A-1:0] MemAddress;
  logic [W-1:0] MemDataIn;
  logic [W-1:0] MemDataOut;
  // Status
  logic         Busy;
  logic         Done;

  modport slave (
`ifdef DATA_MEM_COPY_FILL_EN
    input  Fill,
    input  FillValue,
`endif
    input  Start,
    input  SrcAddr,
    input  DstAddr,
    input  Length,
    input  CpuWriteEn,
    input  CpuAddress,
    input  CpuDataIn,
    output CpuDataOut,
    output MemWriteEn,
    output MemAddress,
    output MemDataIn,
    input  MemDataOut,
    output Busy,
    output Done
  );

  modport master (
`ifdef DATA_MEM_COPY_FILL_EN
    output Fill,
    output FillValue,
`endif
    output Start,
    output SrcAddr,
    output DstAddr,
    output Length,
    output CpuWriteEn,
    output CpuAddress,
    output CpuDataIn,
    input  CpuDataOut,
    input  MemWriteEn,
    input  MemAddress,
    input  MemDataIn,
    output MemDataOut,
    input  Busy,
    input  Done
  );
endinterface

`default_nettype wire

// File: rtl/data_mem_copy_engine.sv
// ============================================================================
// Module      : data_mem_copy_engine
// Description : Block-move engine sitting in front of the data memory. The
//               memory port belongs to the CPU while idle; on Start the FSM
//               copies Length words from SrcAddr to DstAddr one word at a
//               time (RD then WR), pulses Done and hands the port back.
//               Optional macro DATA_MEM_COPY_FILL_EN adds a fill mode that
//               writes FillValue to every destination word with no reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_copy_engine #(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic                   Clk,
  input  logic                   Reset,
  data_mem_copy_engine_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [A-1:0] c_one = {{(A-1){1'b0}}, 1'b1};

  state_t       r_state;
  state_t       w_state_next;
  logic [A-1:0] r_src_ptr;
  logic [A-1:0] r_dst_ptr;
  logic [A-1:0] r_count;
  logic [W-1:0] r_buf;

  logic         w_start_fill;
  logic         w_fill_mode;
  logic [W-1:0] w_fill_value;

  logic         w_mem_we;
  logic [A-1:0] w_mem_addr;
  logic [W-1:0] w_mem_din;
  logic         w_busy;
  logic         w_done;

`ifdef DATA_MEM_COPY_FILL_EN
  logic         r_fill;
  logic [W-1:0] r_fill_value;

  // Fill mode and value are captured together with the copy request
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_fill       <= 1'b0;
      r_fill_value <= '0;
    end else if (r_state == S_IDLE && bus.Start) begin
      r_fill       <= bus.Fill;
      r_fill_value <= bus.FillValue;
    end
  end

  assign w_start_fill = bus.Fill;
  assign w_fill_mode  = r_fill;
  assign w_fill_value = r_fill_value;
`else
  assign w_start_fill = 1'b0;
  assign w_fill_mode  = 1'b0;
  assign w_fill_value = '0;
`endif

  // State register; reset aborts any copy in progress immediately
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Pointer, counter and read-buffer updates for each phase of the copy
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_src_ptr <= '0;
      r_dst_ptr <= '0;
      r_count   <= '0;
      r_buf     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.Start) begin
            r_src_ptr <= bus.SrcAddr;
            r_dst_ptr <= bus.DstAddr;
            r_count   <= bus.Length;
          end
        end
        S_RD: begin
          r_buf     <= bus.MemDataOut;
          r_src_ptr <= r_src_ptr + c_one;
        end
        S_WR: begin
          r_dst_ptr <= r_dst_ptr + c_one;
          r_count   <= r_count - c_one;
        end
        default: ;
      endcase
    end
  end

  // Next-state decode and memory-port ownership mux
  always_comb begin
    w_state_next = r_state;
    w_mem_addr   = bus.CpuAddress;
    w_mem_din    = bus.CpuDataIn;
    w_mem_we     = bus.CpuWriteEn;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.Start) begin
          if (bus.Length == '0) w_state_next = S_DONE;
          else if (w_start_fill) w_state_next = S_WR;
          else                   w_state_next = S_RD;
        end
      end
      S_RD: begin
        w_mem_addr   = r_src_ptr;
        w_mem_we     = 1'b0;
        w_busy       = 1'b1;
        w_state_next = S_WR;
      end
      S_WR: begin
        w_mem_addr = r_dst_ptr;
        w_mem_din  = w_fill_mode ? w_fill_value : r_buf;
        w_mem_we   = 1'b1;
        w_busy     = 1'b1;
        if (r_count == c_one) w_state_next = S_DONE;
        else if (w_fill_mode) w_state_next = S_WR;
        else                  w_state_next = S_RD;
      end
      S_DONE: begin
        w_mem_addr   = r_dst_ptr;
        w_mem_din    = r_buf;
        w_mem_we     = 1'b0;
        w_busy       = 1'b1;
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Write strobe is gated by reset so the memory's reset preload survives
  assign bus.MemWriteEn = w_mem_we & ~Reset;
  assign bus.MemAddress = w_mem_addr;
  assign bus.MemDataIn  = w_mem_din;
  assign bus.CpuDataOut = bus.MemDataOut;
  assign bus.Busy       = w_busy;
  assign bus.Done       = w_done;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_copy_engine.sv
// ============================================================================
// Module      : tb_data_mem_copy_engine
// Description : Self-checking bench for data_mem_copy_engine. Holds the data
//               memory itself plus a word-array reference model updated by
//               plain ascending word moves; random CPU traffic and Start
//               pulses are thrown at the engine while it is busy.
//               Honours DATA_MEM_COPY_FILL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_copy_engine;

  localparam int W = 8;
  localparam int A = 8;
  localparam int DEPTH = 1 << A;

  logic Clk;
  logic Reset;

  data_mem_copy_engine_if #(.W(W), .A(A)) bus ();

  data_mem_copy_engine #(.W(W), .A(A)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  logic [W-1:0] mem     [DEPTH];
  logic [W-1:0] ref_mem [DEPTH];
  logic         pl_all;

  int n_checks = 0;
  int n_fail   = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Data memory: combinational read, clocked write, bulk preload from the bench
  always @(posedge Clk) begin
    if (pl_all) mem <= ref_mem;
    else if (bus.MemWriteEn) mem[bus.MemAddress] <= bus.MemDataIn;
  end
  assign bus.MemDataOut = mem[bus.MemAddress];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int mem_diffs();
    int d = 0;
    for (int i = 0; i < DEPTH; i++)
      if (mem[i] !== ref_mem[i]) d++;
    return d;
  endfunction

  task automatic sync_mem();
    @(negedge Clk);
    pl_all = 1'b1;
    @(posedge Clk);
    #1 pl_all = 1'b0;
  endtask

  task automatic cpu_store(input logic [A-1:0] addr, input logic [W-1:0] data);
    @(negedge Clk);
    bus.CpuWriteEn = 1'b1;
    bus.CpuAddress = addr;
    bus.CpuDataIn  = data;
    @(posedge Clk);
    #1 bus.CpuWriteEn = 1'b0;
    ref_mem[addr] = data;
  endtask

  task automatic cpu_load(input string tag, input logic [A-1:0] addr);
    @(negedge Clk);
    bus.CpuAddress = addr;
    #1 check(tag, 32'(bus.CpuDataOut), 32'(ref_mem[addr]));
  endtask

  // One block operation: model update, timing, write count and memory image
  task automatic run_copy(input string tag, input logic [A-1:0] src, input logic [A-1:0] dst,
                          input logic [A-1:0] len, input logic fill, input logic [W-1:0] fv);
    int exp_cyc, busy_cyc, wr_cyc, done_cyc;
    logic [A-1:0] sa, da;
    busy_cyc = 0;
    wr_cyc   = 0;
    done_cyc = 0;
    for (int i = 0; i < int'(len); i++) begin
      sa = src + A'(i);
      da = dst + A'(i);
      ref_mem[da] = fill ? fv : ref_mem[sa];
    end
    if (len == 0)  exp_cyc = 1;
    else if (fill) exp_cyc = int'(len) + 1;
    else           exp_cyc = 2 * int'(len) + 1;

    @(negedge Clk);
    bus.Start   = 1'b1;
    bus.SrcAddr = src;
    bus.DstAddr = dst;
    bus.Length  = len;
`ifdef DATA_MEM_COPY_FILL_EN
    bus.Fill      = fill;
    bus.FillValue = fv;
`endif
    @(posedge Clk);
    #1 bus.Start = 1'b0;
    for (int c = 1; c <= 600; c++) begin
      @(negedge Clk);
      if (bus.Busy) busy_cyc++;
      if (bus.MemWriteEn) wr_cyc++;
      if (bus.Done) begin
        done_cyc       = c;
        bus.Start      = 1'b0;
        bus.CpuWriteEn = 1'b0;
        break;
      end
      bus.Start      = 1'($urandom);
      bus.SrcAddr    = A'($urandom);
      bus.DstAddr    = A'($urandom);
      bus.Length     = A'($urandom);
      bus.CpuWriteEn = 1'($urandom);
      bus.CpuAddress = (c == 1) ? A'(50) : A'($urandom);
      bus.CpuDataIn  = W'($urandom);
    end
    check({tag, " done_cycle"}, 32'(done_cyc), 32'(exp_cyc));
    check({tag, " busy_cycles"}, 32'(busy_cyc), 32'(exp_cyc));
    check({tag, " write_cycles"}, 32'(wr_cyc), 32'(len));
    @(negedge Clk);
    check({tag, " idle_after"}, {30'd0, bus.Busy, bus.Done}, 32'd0);
    check({tag, " mem_image"}, 32'(mem_diffs()), 32'd0);
  endtask

  initial begin
    logic [A-1:0] r_src, r_dst, r_len;
    logic         r_fill;
    logic [W-1:0] r_fv;

    pl_all         = 1'b0;
    Reset          = 1'b1;
    bus.Start      = 1'b0;
    bus.SrcAddr    = '0;
    bus.DstAddr    = '0;
    bus.Length     = '0;
    bus.CpuWriteEn = 1'b1;
    bus.CpuAddress = A'(77);
    bus.CpuDataIn  = W'(8'h5A);
`ifdef DATA_MEM_COPY_FILL_EN
    bus.Fill      = 1'b0;
    bus.FillValue = '0;
`endif
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = W'($urandom);
    ref_mem[0] = 8'd1;
    ref_mem[1] = 8'd64;
    ref_mem[2] = 8'd10;
    ref_mem[3] = 8'd15;

    // Reset state: outputs idle, CPU store strobe suppressed at the memory
    sync_mem();
    @(negedge Clk);
    check("reset_busy", 32'(bus.Busy), 32'd0);
    check("reset_done", 32'(bus.Done), 32'd0);
    check("reset_we_gated", 32'(bus.MemWriteEn), 32'd0);
    check("reset_mem", 32'(mem_diffs()), 32'd0);
    bus.CpuWriteEn = 1'b0;
    Reset = 1'b0;

    // Directed scenarios
    run_copy("basic4", A'(0), A'(16), A'(4), 1'b0, '0);
    check("basic4_word16", 32'(mem[16]), 32'd1);
    check("basic4_word19", 32'(mem[19]), 32'd15);
    run_copy("len0", A'(5), A'(6), A'(0), 1'b0, '0);

    ref_mem[254] = 8'hA0;
    ref_mem[255] = 8'hA1;
    ref_mem[0]   = 8'hA2;
    ref_mem[1]   = 8'hA3;
    sync_mem();
    run_copy("src_wrap", A'(254), A'(100), A'(4), 1'b0, '0);
    check("src_wrap_word103", 32'(mem[103]), 32'hA3);
    run_copy("dst_wrap", A'(100), A'(254), A'(4), 1'b0, '0);
    check("dst_wrap_word1", 32'(mem[1]), 32'hA3);

    ref_mem[10] = 8'd5;
    ref_mem[50] = 8'hC7;
    sync_mem();
    run_copy("overlap", A'(10), A'(11), A'(3), 1'b0, '0);
    check("overlap_word13", 32'(mem[13]), 32'd5);
    check("overlap_cpu_drop", 32'(mem[50]), 32'hC7);

    // CPU path while idle
    cpu_store(A'(200), W'(8'h99));
    cpu_load("cpu_load_200", A'(200));
    cpu_load("cpu_load_16", A'(16));

    // Asynchronous reset after the second write of an 8-word copy
    ref_mem[40] = ref_mem[20];
    ref_mem[41] = ref_mem[21];
    @(negedge Clk);
    bus.Start   = 1'b1;
    bus.SrcAddr = A'(20);
    bus.DstAddr = A'(40);
    bus.Length  = A'(8);
    @(posedge Clk);
    #1 bus.Start = 1'b0;
    repeat (5) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    check("abort_busy", 32'(bus.Busy), 32'd0);
    check("abort_done", 32'(bus.Done), 32'd0);
    check("abort_we", 32'(bus.MemWriteEn), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    check("abort_mem", 32'(mem_diffs()), 32'd0);
    run_copy("after_abort", A'(60), A'(70), A'(3), 1'b0, '0);

`ifdef DATA_MEM_COPY_FILL_EN
    run_copy("fill5", A'(0), A'(200), A'(5), 1'b1, W'(8'h3C));
    check("fill5_word204", 32'(mem[204]), 32'h3C);
`endif

    // Randomised block operations with CPU traffic in between
    for (int t = 0; t < 25; t++) begin
      r_src = A'($urandom);
      r_dst = A'($urandom);
      r_len = A'($urandom_range(0, 40));
      r_fv  = W'($urandom);
`ifdef DATA_MEM_COPY_FILL_EN
      r_fill = 1'($urandom);
`else
      r_fill = 1'b0;
`endif
      run_copy($sformatf("rand%0d", t), r_src, r_dst, r_len, r_fill, r_fv);
      cpu_store(A'($urandom), W'($urandom));
      cpu_load($sformatf("rand%0d_load", t), r_dst);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/data_mem_copy_engine.md
Name: data_mem_copy_engine

Overview:
- Block-move engine placed directly upstream of the data memory (single shared address pointer, combinational read, clocked write).
- Muxes the memory port between the CPU load/store path and an internal copy FSM.
- On request, the FSM copies Length words from SrcAddr to DstAddr, then returns the port to the CPU.

Parameters:
W, 8, data word width; must match the data memory.
A, 8, address width; memory depth is 2**A.

Ports:
Clk  input  1  system clock, rising edge.
Reset  input  1  asynchronous, active-high reset.
Start  input  1  copy request; sampled only in IDLE.
SrcAddr  input  A  first source address.
DstAddr  input  A  first destination address.
Length  input  A  word count, 0..2**A-1.
CpuWriteEn  input  1  CPU store strobe.
CpuAddress  input  A  CPU load/store address.
CpuDataIn  input  W  CPU store data.
CpuDataOut  output  W  load data to CPU; wired to MemDataOut.
MemWriteEn  output  1  drives the memory WriteEn.
MemAddress  output  A  drives the memory DataAddress.
MemDataIn  output  W  drives the memory DataIn.
MemDataOut  input  W  memory DataOut (combinational).
Busy  output  1  high in RD, WR and DONE.
Done  output  1  one-cycle completion pulse.

Behaviour:
- Clocking and reset: one clock (Clk); Reset is asynchronous and active-high.
- Reset values: state=IDLE; src_ptr, dst_ptr, count, buf = 0; Busy=0, Done=0.
- MemWriteEn is forced to 0 combinationally while Reset is high, so the memory's own reset preload is never overwritten.
- FSM states: IDLE, RD, WR, DONE.
- IDLE:
  - Memory port is owned by the CPU: MemAddress=CpuAddress, MemDataIn=CpuDataIn, MemWriteEn=CpuWriteEn.
  - On a posedge with Start=1, latch src_ptr=SrcAddr, dst_ptr=DstAddr, count=Length.
  - Next state is RD, or DONE if Length==0.
- RD:
  - MemAddress=src_ptr, MemWriteEn=0.
  - At the posedge, buf<=MemDataOut and src_ptr<=src_ptr+1 (mod 2**A); go to WR.
- WR:
  - MemAddress=dst_ptr, MemDataIn=buf, MemWriteEn=1; the memory commits the write at the posedge.
  - Same edge: dst_ptr<=dst_ptr+1 (mod 2**A), count<=count-1.
  - Go to DONE if count==1, else go to RD.
- DONE:
  - Done=1, MemWriteEn=0, MemAddress=dst_ptr; go to IDLE.
- Latency: N words take 2N cycles of RD/WR; Done is high in cycle 2N+1 after the Start edge (cycle 1 for N=0). Busy falls on the same edge Done falls.
- CPU path while Busy:
  - CpuWriteEn is ignored; the store is dropped, not queued.
  - CpuDataOut shows whatever address the engine is driving.
  - Software must poll Busy before issuing accesses.
- Start while Busy is ignored; there is no queueing.
- Address wrap-around: pointers wrap modulo 2**A. Example: SrcAddr=254, Length=4 reads 254, 255, 0, 1.
- Overlap: copy is strictly ascending, one word at a time. If DstAddr is in (SrcAddr, SrcAddr+Length), later reads see already-copied data; this is defined behaviour (replicating pattern), not an error.
- Reset mid-copy: the engine returns to IDLE immediately; words already written stay written; Done is not pulsed.
- Start and Reset together: Reset wins.

Optional Feature:
- Macro: DATA_MEM_COPY_FILL_EN.
- When defined:
  - Adds ports Fill (input, 1) and FillValue (input, W), both latched with Start.
  - If Fill=1, the FSM skips RD and stays in WR, writing FillValue to dst_ptr each cycle.
  - N words take N cycles; Done is high in cycle N+1.
  - src_ptr is unused in fill mode.
- When undefined:
  - Ports are absent; behaviour is copy-only as above.

Test Plan:
- Reset, preload mem[0..3]=1,64,10,15; Start with Src=0, Dst=16, Len=4 -> Busy high for 9 cycles; Done high in cycle 9; mem[16..19]=1,64,10,15; no other address written.
- Len=0, Start -> Done in cycle 1; MemWriteEn never high; memory unchanged.
- Src=254, Dst=100, Len=4, mem[254]=A0, mem[255]=A1, mem[0]=A2, mem[1]=A3 -> mem[100..103]=A0..A3 (src wrap). Repeat with Dst=254 -> writes land at 254, 255, 0, 1.
- Overlap: mem[10]=5, Src=10, Dst=11, Len=3 -> mem[11..13]=5,5,5. CPU store to address 50 issued mid-copy -> mem[50] unchanged.
- Assert Reset asynchronously (between clock edges) after the 2nd WR of an 8-word copy -> Busy/Done drop immediately; exactly 2 destination words written; next Start runs normally.
- (DATA_MEM_COPY_FILL_EN) Fill=1, FillValue=8'h3C, Dst=200, Len=5 -> mem[200..204]=3C; Done high in cycle 6; no read cycles.
